y86_decode_regread: RTL and testbench

- Decode-stage register-file reader for the pipelined Y86-64 core; the read/forwarding counterpart to the write-back stage.
- Holds the 15×64-bit architectural register file and accepts the W-stage write ports.
- Derives source and destination register IDs from the D-stage instruction, reads both operands and forwards newer values from the E/M/W stages.
- Launches the result into the E pipeline register, which supports stall and bubble controls.

---
 rtl/y86_decode_regread.sv | 134 +++++++++++++
 tb/tb_y86_decode_regread.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_decode_regread.sv
// rtl/y86_decode_regread.sv - Y86-64 decode stage: register file, operand forwarding, E pipeline register
module y86_decode_regread #(
  parameter int NREG = 15,
  parameter int W    = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   D_icode,
  input  logic [3:0]   D_ifun,
  input  logic [3:0]   D_rA,
  input  logic [3:0]   D_rB,
  input  logic [W-1:0] D_valC,
  input  logic [W-1:0] D_valP,
  input  logic         E_stall,
  input  logic         E_bubble,
  input  logic [3:0]   e_dstE,
  input  logic [W-1:0] e_valE,
  input  logic [3:0]   M_dstE,
  input  logic [W-1:0] M_valE,
  input  logic [3:0]   M_dstM,
  input  logic [W-1:0] m_valM,
  input  logic [3:0]   W_dstE,
  input  logic [W-1:0] W_valE,
  input  logic [3:0]   W_dstM,
  input  logic [W-1:0] W_valM,
  output logic [3:0]   d_srcA,
  output logic [3:0]   d_srcB,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_ifun,
  output logic [3:0]   E_srcA,
  output logic [3:0]   E_srcB,
  output logic [3:0]   E_dstE,
  output logic [3:0]   E_dstM,
  output logic [W-1:0] E_valC,
  output logic [W-1:0] E_valA,
  output logic [W-1:0] E_valB
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RRSP     = 4'h4;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [W-1:0] r_regs [NREG];
  logic [3:0]   w_dstE;
  logic [3:0]   w_dstM;
  logic [W-1:0] w_rf_a;
  logic [W-1:0] w_rf_b;
  logic [W-1:0] w_valA;
  logic [W-1:0] w_valB;

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (D_icode)
      I_RRMOVQ: begin d_srcA = D_rA; w_dstE = D_rB; end
      I_IRMOVQ: begin w_dstE = D_rB; end
      I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
      I_MRMOVQ: begin d_srcB = D_rB; w_dstM = D_rA; end
      I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; w_dstE = D_rB; end
      I_CALL:   begin d_srcB = RRSP; w_dstE = RRSP; end
      I_RET:    begin d_srcA = RRSP; d_srcB = RRSP; w_dstE = RRSP; end
      I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RRSP; w_dstE = RRSP; end
      I_POPQ:   begin d_srcA = RRSP; d_srcB = RRSP; w_dstE = RRSP; w_dstM = D_rA; end
      default:  begin end
    endcase
  end

  assign w_rf_a = (d_srcA == RNONE) ? '0 : r_regs[d_srcA];
  assign w_rf_b = (d_srcB == RNONE) ? '0 : r_regs[d_srcB];

  // Youngest producer wins; W forwarding also covers the same-cycle write/read case.
  function automatic logic [W-1:0] fwd(input logic [3:0] src, input logic [W-1:0] rf_val);
    if (src == RNONE)       return '0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf_val;
  endfunction

  always_comb begin
    w_valA = fwd(d_srcA, w_rf_a);
    w_valB = fwd(d_srcB, w_rf_b);
    if (D_icode == I_CALL || D_icode == I_JXX) w_valA = D_valP;
  end

  // dstM is written after dstE so a popq to %rsp keeps the loaded value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (W_dstE != RNONE) r_regs[W_dstE] <= W_valE;
      if (W_dstM != RNONE) r_regs[W_dstM] <= W_valM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || E_bubble) begin
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
    end else if (!E_stall) begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
      E_dstE  <= w_dstE;
      E_dstM  <= w_dstM;
      E_valC  <= D_valC;
      E_valA  <= w_valA;
      E_valB  <= w_valB;
    end
  end

endmodule

// File: tb/tb_y86_decode_regread.sv
// tb/tb_y86_decode_regread.sv - bench for y86_decode_regread
module tb_y86_decode_regread;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        E_stall, E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB;

  always #5 clk = ~clk;

  y86_decode_regread dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: operand roles per icode (0=none, 1=rA, 2=rB, 3=%rsp)
  int t_sa [16] = '{0,0,1,0,1,0,1,0,0,3,1,3,0,0,0,0};
  int t_sb [16] = '{0,0,0,0,2,2,2,0,3,3,3,3,0,0,0,0};
  int t_de [16] = '{0,0,2,2,0,0,2,0,3,3,3,3,0,0,0,0};
  int t_dm [16] = '{0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0};

  typedef struct {
    logic [3:0]  icode, ifun, srcA, srcB, dstE, dstM;
    logic [63:0] valC, valA, valB;
  } ereg_t;

  logic [63:0] m_reg [15];
  ereg_t       m_e;

  function automatic logic [3:0] role(input int code, input logic [3:0] ra, input logic [3:0] rb);
    if (code == 1) return ra;
    if (code == 2) return rb;
    if (code == 3) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] src);
    logic [3:0]  pd [5];
    logic [63:0] pv [5];
    pd = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    pv = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (src == 4'hF) return 64'd0;
    for (int k = 0; k < 5; k++)
      if (pd[k] == src) return pv[k];
    return m_reg[src];
  endfunction

  task automatic cycle();
    ereg_t nx, nop;
    #1;
    nx.icode = D_icode;
    nx.ifun  = D_ifun;
    nx.srcA  = role(t_sa[D_icode], D_rA, D_rB);
    nx.srcB  = role(t_sb[D_icode], D_rA, D_rB);
    nx.dstE  = role(t_de[D_icode], D_rA, D_rB);
    nx.dstM  = role(t_dm[D_icode], D_rA, D_rB);
    nx.valC  = D_valC;
    nx.valA  = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : m_read(nx.srcA);
    nx.valB  = m_read(nx.srcB);
    chk("m_d_srcA", d_srcA, nx.srcA);
    chk("m_d_srcB", d_srcB, nx.srcB);
    nop = '{4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0};
    if (reset || E_bubble) m_e = nop;
    else if (!E_stall)     m_e = nx;
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 15; k++) m_reg[k] = 64'd0;
    end else begin
      if (W_dstE != 4'hF) m_reg[W_dstE] = W_valE;
      if (W_dstM != 4'hF) m_reg[W_dstM] = W_valM;
    end
    #1;
    chk("m_E_icode", E_icode, m_e.icode);
    chk("m_E_ifun",  E_ifun,  m_e.ifun);
    chk("m_E_srcA",  E_srcA,  m_e.srcA);
    chk("m_E_srcB",  E_srcB,  m_e.srcB);
    chk("m_E_dstE",  E_dstE,  m_e.dstE);
    chk("m_E_dstM",  E_dstM,  m_e.dstM);
    chk("m_E_valC",  E_valC,  m_e.valC);
    chk("m_E_valA",  E_valA,  m_e.valA);
    chk("m_E_valB",  E_valB,  m_e.valB);
  endtask

  task automatic idle();
    reset = 0; E_stall = 0; E_bubble = 0;
    D_icode = 4'h1; D_ifun = 0; D_rA = 4'hF; D_rB = 4'hF; D_valC = 0; D_valP = 0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
  endtask

  function automatic logic [3:0] rid();
    int r;
    r = $urandom_range(0, 7);
    return (r == 7) ? 4'hF : 4'(r);
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  typedef struct {
    logic [3:0]  ic, rA, rB;
    logic [63:0] valP;
    logic [3:0]  edst;  logic [63:0] eval;
    logic [3:0]  mdstM; logic [63:0] mvalM;
    logic [3:0]  mdstE; logic [63:0] mvalE;
    logic [3:0]  xsa, xsb, xde, xdm;
    logic [63:0] xva, xvb;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{4'h2,4'h1,4'h3,64'h0,    4'h1,64'h11,4'hF,64'h0, 4'hF,64'h0, 4'h1,4'hF,4'h3,4'hF,64'h11,64'h0};
    tbl[1]  = '{4'h3,4'hF,4'h6,64'h0,    4'hF,64'h99,4'hF,64'h0, 4'hF,64'h0, 4'hF,4'hF,4'h6,4'hF,64'h0,64'h0};
    tbl[2]  = '{4'h4,4'h7,4'h8,64'h0,    4'hF,64'h0, 4'h8,64'h22,4'hF,64'h0, 4'h7,4'h8,4'hF,4'hF,64'h0,64'h22};
    tbl[3]  = '{4'h5,4'h9,4'hA,64'h0,    4'hF,64'h0, 4'hF,64'h0, 4'hA,64'h33,4'hF,4'hA,4'hF,4'h9,64'h0,64'h33};
    tbl[4]  = '{4'h6,4'h2,4'h3,64'h0,    4'h3,64'h44,4'hF,64'h0, 4'h2,64'h55,4'h2,4'h3,4'h3,4'hF,64'h55,64'h44};
    tbl[5]  = '{4'h7,4'hF,4'hF,64'h1234, 4'hF,64'h0, 4'hF,64'h0, 4'hF,64'h0, 4'hF,4'hF,4'hF,4'hF,64'h1234,64'h0};
    tbl[6]  = '{4'h8,4'hF,4'hF,64'h40,   4'h4,64'h77,4'hF,64'h0, 4'hF,64'h0, 4'hF,4'h4,4'h4,4'hF,64'h40,64'h77};
    tbl[7]  = '{4'h9,4'hF,4'hF,64'h0,    4'hF,64'h0, 4'h4,64'h88,4'hF,64'h0, 4'h4,4'h4,4'h4,4'hF,64'h88,64'h88};
    tbl[8]  = '{4'hA,4'h5,4'hF,64'h0,    4'h5,64'h66,4'h4,64'h10,4'hF,64'h0, 4'h5,4'h4,4'h4,4'hF,64'h66,64'h10};
    tbl[9]  = '{4'hB,4'hB,4'hF,64'h0,    4'hF,64'h0, 4'hF,64'h0, 4'hF,64'h0, 4'h4,4'h4,4'h4,4'hB,64'h0,64'h0};
    tbl[10] = '{4'hC,4'h1,4'h2,64'h0,    4'h1,64'h5, 4'hF,64'h0, 4'hF,64'h0, 4'hF,4'hF,4'hF,4'hF,64'h0,64'h0};
    tbl[11] = '{4'h0,4'hF,4'hF,64'h0,    4'hF,64'h0, 4'hF,64'h0, 4'hF,64'h0, 4'hF,4'hF,4'hF,4'hF,64'h0,64'h0};
    tbl[12] = '{4'h2,4'h6,4'hF,64'h0,    4'h6,64'hE1,4'h6,64'hE2,4'h6,64'hE3,4'h6,4'hF,4'hF,4'hF,64'hE1,64'h0};

    idle();
    reset = 1;
    cycle();
    cycle();
    chk("rst_E_icode", E_icode, 4'h1);
    chk("rst_E_dstE",  E_dstE,  4'hF);
    chk("rst_E_valA",  E_valA,  64'h0);

    // Table vectors, register file still all zero
    for (int i = 0; i < 13; i++) begin
      idle();
      D_icode = tbl[i].ic; D_rA = tbl[i].rA; D_rB = tbl[i].rB; D_valP = tbl[i].valP;
      D_valC = 64'h5000 + 64'(i);
      e_dstE = tbl[i].edst;  e_valE = tbl[i].eval;
      M_dstM = tbl[i].mdstM; m_valM = tbl[i].mvalM;
      M_dstE = tbl[i].mdstE; M_valE = tbl[i].mvalE;
      #1;
      chk($sformatf("t%0d_d_srcA", i), d_srcA, tbl[i].xsa);
      chk($sformatf("t%0d_d_srcB", i), d_srcB, tbl[i].xsb);
      cycle();
      chk($sformatf("t%0d_E_icode", i), E_icode, tbl[i].ic);
      chk($sformatf("t%0d_E_srcA", i),  E_srcA,  tbl[i].xsa);
      chk($sformatf("t%0d_E_srcB", i),  E_srcB,  tbl[i].xsb);
      chk($sformatf("t%0d_E_dstE", i),  E_dstE,  tbl[i].xde);
      chk($sformatf("t%0d_E_dstM", i),  E_dstM,  tbl[i].xdm);
      chk($sformatf("t%0d_E_valA", i),  E_valA,  tbl[i].xva);
      chk($sformatf("t%0d_E_valB", i),  E_valB,  tbl[i].xvb);
    end

    // Write reg[3], read it, then reset clears it
    idle(); W_dstE = 4'h3; W_valE = 64'h55; cycle();
    idle(); D_icode = 4'h2; D_rA = 4'h3; cycle();
    chk("rf_r3_before_reset", E_valA, 64'h55);
    idle(); reset = 1; cycle();
    chk("mid_rst_E_icode", E_icode, 4'h1);
    chk("mid_rst_E_dstE",  E_dstE,  4'hF);
    idle(); D_icode = 4'h2; D_rA = 4'h3; cycle();
    chk("rf_r3_after_reset", E_valA, 64'h0);

    // Same-cycle W write and read, then from the file
    idle(); D_icode = 4'h2; D_rA = 4'h2; W_dstE = 4'h2; W_valE = 64'hAA; cycle();
    chk("w_fwd_same_cycle", E_valA, 64'hAA);
    idle(); D_icode = 4'h2; D_rA = 4'h2; cycle();
    chk("rf_after_write", E_valA, 64'hAA);

    // Forwarding priority e > M_dstM > W
    idle(); D_icode = 4'h2; D_rA = 4'h5;
    e_dstE = 4'h5; e_valE = 64'h11; M_dstM = 4'h5; m_valM = 64'h22; W_dstE = 4'h5; W_valE = 64'h33;
    cycle(); chk("prio_e", E_valA, 64'h11);
    e_dstE = 4'hF; cycle(); chk("prio_m", E_valA, 64'h22);
    M_dstM = 4'hF; cycle(); chk("prio_w", E_valA, 64'h33);

    // Dual write to the same register: W_valM wins
    idle(); D_icode = 4'hB; D_rA = 4'h4;
    W_dstE = 4'h4; W_valE = 64'h100; W_dstM = 4'h4; W_valM = 64'h200; cycle();
    chk("popq_fwd_valM", E_valA, 64'h200);
    idle(); D_icode = 4'h2; D_rA = 4'h4; cycle();
    chk("popq_rf_r4", E_valA, 64'h200);

    // call: valP beats forwarding on valA
    idle(); D_icode = 4'h8; D_valP = 64'h40; e_dstE = 4'h4; e_valE = 64'h999; cycle();
    chk("call_valA", E_valA, 64'h40);
    chk("call_srcB", E_srcB, 4'h4);
    chk("call_dstE", E_dstE, 4'h4);

    // Stall holds, bubble overrides stall
    idle(); D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2; D_valC = 64'hC0; cycle();
    idle(); E_stall = 1; D_icode = 4'h3; D_rB = 4'h5; D_valC = 64'hDEAD; cycle();
    chk("stall1_icode", E_icode, 4'h6);
    chk("stall1_valC",  E_valC,  64'hC0);
    D_icode = 4'h5; D_rA = 4'h7; D_valC = 64'hBEEF; cycle();
    chk("stall2_icode", E_icode, 4'h6);
    chk("stall2_srcA",  E_srcA,  4'h1);
    E_bubble = 1; cycle();
    chk("bubble_icode", E_icode, 4'h1);
    chk("bubble_dstE",  E_dstE,  4'hF);
    chk("bubble_valC",  E_valC,  64'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 39) == 0);
      E_bubble = ($urandom_range(0, 15) == 0);
      E_stall  = ($urandom_range(0, 7) == 0);
      D_icode  = 4'($urandom_range(0, 15));
      D_ifun   = 4'($urandom_range(0, 15));
      D_rA = rid(); D_rB = rid();
      D_valC = r64(); D_valP = r64();
      e_dstE = rid(); M_dstE = rid(); M_dstM = rid(); W_dstE = rid(); W_dstM = rid();
      e_valE = r64(); M_valE = r64(); m_valM = r64(); W_valE = r64(); W_valM = r64();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
